// File: rtl/spec_video_gen_if.sv
// Bus bundle between the raster video generator (master) and the
// video-RAM arbiter / DAC side (slave).
interface spec_video_gen_if #(
    parameter int H_TOTAL = 512,
    parameter int COL_W   = 5
);
    localparam int VW = $clog2(H_TOTAL) - 3 + 8;

    logic [1:0]       mode;
    logic [3:0]       border;
    logic [15:0]      vdata;
    logic [VW-1:0]    vram;
    logic             rdvid;
    logic             hsync;
    logic             vsync;
    logic             blank;
    logic [COL_W-1:0] red;
    logic [COL_W-1:0] green;
    logic [COL_W-1:0] blue;
    logic             frame_start;

    modport master (
        input  mode, border, vdata,
        output vram, rdvid, hsync, vsync, blank, red, green, blue, frame_start
    );

    modport slave (
        output mode, border, vdata,
        input  vram, rdvid, hsync, vsync, blank, red, green, blue, frame_start
    );
endinterface

// File: rtl/spec_video_gen.sv
// Raster video generator: sync/blank timing with line repetition, one byte
// fetch per 8 clocks and a mono/colour8/colour16 pixel serialiser with border.
module spec_video_gen #(
    parameter int H_TOTAL     = 512,
    parameter int H_ACT_START = 128,
    parameter int H_ACT_END   = 511,
    parameter int H_VIS_START = 96,
    parameter int HS_START    = 29,
    parameter int HS_END      = 87,
    parameter int V_TOTAL     = 312,
    parameter int V_ACTIVE    = 256,
    parameter int V_VIS       = 288,
    parameter int VS_START    = 278,
    parameter int VS_END      = 282,
    parameter int VREP_LOG2   = 1,
    parameter int COL_W       = 5
) (
    input  logic             clkVid,
    input  logic             rst_n,
    spec_video_gen_if.master vif
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int LW = $clog2(V_TOTAL << VREP_LOG2);

    localparam logic [HW-1:0] L_H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] L_H_ACT_S   = HW'(H_ACT_START);
    localparam logic [HW:0]   L_H_ACT_E_X = (HW + 1)'(H_ACT_END);
    localparam logic [HW-1:0] L_H_VIS_S   = HW'(H_VIS_START);
    localparam logic [HW-1:0] L_HS_S      = HW'(HS_START);
    localparam logic [HW-1:0] L_HS_E      = HW'(HS_END);
    localparam logic [LW-1:0] L_LINE_LAST = LW'((V_TOTAL << VREP_LOG2) - 1);
    localparam logic [LW-1:0] L_V_ACT     = LW'(V_ACTIVE);
    localparam logic [LW-1:0] L_V_VIS     = LW'(V_VIS);
    localparam logic [LW-1:0] L_VS_S      = LW'(VS_START);
    localparam logic [LW-1:0] L_VS_E      = LW'(VS_END);

    localparam logic [1:0] MODE_MONO = 2'd0;
    localparam logic [1:0] MODE_C16  = 2'd2;

    // Half-scale when intensity is clear, full-scale when set.
    function automatic logic [COL_W-1:0] f_expand(input logic ch, input logic inten);
        logic [COL_W-1:0] v;
        if (!ch) begin
            v = '0;
        end else if (inten) begin
            v = '1;
        end else begin
            v = '0;
            v[COL_W-1] = 1'b1;
        end
        return v;
    endfunction

    logic [HW-1:0]    r_hcnt;
    logic [LW-1:0]    r_line;
    logic             r_frame_start;
    logic             r_rdvid;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_blank;
    logic [COL_W-1:0] r_red;
    logic [COL_W-1:0] r_green;
    logic [COL_W-1:0] r_blue;
    logic [1:0]       r_mode;
    logic [3:0]       r_border;
    logic [7:0]       r_shift;
    logic [7:0]       r_attr;
    logic             r_act;
    logic             r_vis;

    logic          w_h_wrap;
    logic          w_l_wrap;
    logic          w_frame_wrap;
    logic [LW-1:0] w_row;
    logic [7:0]    w_row8;
    logic [HW:0]   w_hcnt_x;
    logic          w_act_pre;
    logic          w_vis_pre;
    logic          w_sample;
    logic          w_pix;
    logic [3:0]    w_irgb;

    assign w_h_wrap     = (r_hcnt == L_H_LAST);
    assign w_l_wrap     = (r_line == L_LINE_LAST);
    assign w_frame_wrap = w_h_wrap && w_l_wrap;
    assign w_row        = r_line >> VREP_LOG2;
    assign w_row8       = 8'(w_row);
    assign w_hcnt_x     = {1'b0, r_hcnt};
    assign w_act_pre    = (r_hcnt >= L_H_ACT_S) && (w_hcnt_x <= L_H_ACT_E_X) && (w_row < L_V_ACT);
    assign w_vis_pre    = (r_hcnt >= L_H_VIS_S) && (w_row < L_V_VIS);
    assign w_sample     = (r_hcnt[2:0] == 3'd7);
    // Bit 7 - hcnt[2:0] is the bitwise inverse of the 3-bit phase.
    assign w_pix        = r_shift[~r_hcnt[2:0]];

    assign vif.vram        = {r_hcnt[HW-1:3], w_row8};
    assign vif.rdvid       = r_rdvid;
    assign vif.hsync       = r_hsync;
    assign vif.vsync       = r_vsync;
    assign vif.blank       = r_blank;
    assign vif.red         = r_red;
    assign vif.green       = r_green;
    assign vif.blue        = r_blue;
    assign vif.frame_start = r_frame_start;

    // Horizontal and line counters
    always_ff @(posedge clkVid or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_line <= '0;
        end else if (w_h_wrap) begin
            r_hcnt <= '0;
            r_line <= w_l_wrap ? '0 : r_line + LW'(1);
        end else begin
            r_hcnt <= r_hcnt + HW'(1);
            r_line <= r_line;
        end
    end

    // Registered sync, fetch strobe, frame pulse and per-frame shadow of mode/border
    always_ff @(posedge clkVid or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_rdvid       <= 1'b0;
            r_frame_start <= 1'b0;
            r_mode        <= 2'd0;
            r_border      <= 4'd0;
        end else begin
            r_hsync       <= ~((r_hcnt >= L_HS_S) && (r_hcnt < L_HS_E));
            r_vsync       <= ~((w_row >= L_VS_S) && (w_row < L_VS_E));
            r_rdvid       <= (r_hcnt[2:0] == 3'd0);
            r_frame_start <= w_frame_wrap;
            if (w_frame_wrap) begin
                r_mode   <= vif.mode;
                r_border <= vif.border;
            end
        end
    end

    // Latch pixel byte, attribute and region flags once per fetch group
    always_ff @(posedge clkVid or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 8'd0;
            r_attr  <= 8'd0;
            r_act   <= 1'b0;
            r_vis   <= 1'b0;
        end else if (w_sample) begin
            r_shift <= vif.vdata[7:0];
            r_attr  <= vif.vdata[15:8];
            r_act   <= w_act_pre;
            r_vis   <= w_vis_pre;
        end
    end

    // Select the IRGB colour for the current pixel
    always_comb begin
        w_irgb = 4'h0;
        if (r_act) begin
            case (r_mode)
                MODE_MONO: w_irgb = w_pix ? 4'hF : 4'h0;
                MODE_C16:  w_irgb = w_pix ? r_attr[3:0] : r_attr[7:4];
                default:   w_irgb = w_pix ? {1'b1, r_attr[2:0]} : 4'h0;
            endcase
        end else if (r_vis) begin
            w_irgb = r_border;
        end else begin
            w_irgb = 4'h0;
        end
    end

    // Registered colour channels and blanking
    always_ff @(posedge clkVid or negedge rst_n) begin
        if (!rst_n) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_blank <= 1'b1;
        end else begin
            r_red   <= f_expand(w_irgb[0], w_irgb[3]);
            r_green <= f_expand(w_irgb[1], w_irgb[3]);
            r_blue  <= f_expand(w_irgb[2], w_irgb[3]);
            r_blank <= ~r_act;
        end
    end
endmodule

// File: tb/tb_spec_video_gen.sv
// Self-checking bench for spec_video_gen: small raster geometry, random pixel
// data, expected outputs derived from absolute clock count and input history.
module tb_spec_video_gen;
    localparam int H      = 64;
    localparam int AS     = 16;
    localparam int AE     = 63;
    localparam int VSTART = 8;
    localparam int HSS    = 3;
    localparam int HSE    = 9;
    localparam int VT     = 20;
    localparam int VA     = 12;
    localparam int VV     = 16;
    localparam int VSS    = 17;
    localparam int VSE    = 19;
    localparam int REP    = 1;
    localparam int CW     = 5;
    localparam int F      = H * (VT << REP);
    localparam int NH     = 16384;

    logic clkVid = 1'b0;
    logic rst_n  = 1'b1;
    int   total  = 0;
    int   bad    = 0;
    int   t      = 0;
    bit   rand_vd = 1'b1;
    logic [7:0] pat;

    logic [15:0] vd_hist [NH];
    logic [1:0]  md_hist [NH];
    logic [3:0]  bd_hist [NH];

    spec_video_gen_if #(.H_TOTAL(H), .COL_W(CW)) vif ();

    spec_video_gen #(
        .H_TOTAL(H), .H_ACT_START(AS), .H_ACT_END(AE), .H_VIS_START(VSTART),
        .HS_START(HSS), .HS_END(HSE), .V_TOTAL(VT), .V_ACTIVE(VA), .V_VIS(VV),
        .VS_START(VSS), .VS_END(VSE), .VREP_LOG2(REP), .COL_W(CW)
    ) dut (
        .clkVid(clkVid),
        .rst_n (rst_n),
        .vif   (vif)
    );

    always #5 clkVid = ~clkVid;

    // Counter position during the cycle after edge m.
    function automatic int hc(int m);
        return (m % F) % H;
    endfunction

    function automatic int rw(int m);
        return ((m % F) / H) >> REP;
    endfunction

    function automatic logic [CW-1:0] lvl(logic ch, logic inten);
        if (!ch) return '0;
        if (inten) return '1;
        return CW'(1 << (CW - 1));
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic check_all();
        int q, k, m, j;
        logic act, vis, pix;
        logic [1:0] md;
        logic [3:0] bd, c;
        logic [15:0] vd;
        chk("hsync", 32'(vif.hsync), 32'(!(hc(t - 1) >= HSS && hc(t - 1) < HSE)));
        chk("vsync", 32'(vif.vsync), 32'(!(rw(t - 1) >= VSS && rw(t - 1) < VSE)));
        chk("rdvid", 32'(vif.rdvid), 32'(hc(t - 1) % 8 == 0));
        chk("frame_start", 32'(vif.frame_start), 32'((t % F) == 0));
        chk("vram", 32'(vif.vram), 32'((hc(t) / 8) * 256 + rw(t)));
        // Pixel shown after edge t belongs to raster position t-9.
        q = t - 9; act = 1'b0; vis = 1'b0; pix = 1'b0; vd = 16'h0000;
        md = 2'd0; bd = 4'h0;
        if (q >= 0) begin
            k   = hc(q) % 8;
            m   = q - k + 7;
            act = (hc(m) >= AS) && (hc(m) <= AE) && (rw(m) < VA);
            vis = (hc(m) >= VSTART) && (rw(m) < VV);
            vd  = vd_hist[m];
            pix = vd[7 - k];
        end
        j = (t - 1) / F;
        if (j > 0) begin
            md = md_hist[j * F - 1];
            bd = bd_hist[j * F - 1];
        end
        if (act) begin
            if (md == 2'd2)      c = pix ? vd[11:8] : vd[15:12];
            else if (md == 2'd0) c = pix ? 4'hF : 4'h0;
            else                 c = pix ? {1'b1, vd[10:8]} : 4'h0;
        end else if (vis) begin
            c = bd;
        end else begin
            c = 4'h0;
        end
        chk("blank", 32'(vif.blank), 32'(!act));
        chk("red",   32'(vif.red),   32'(lvl(c[0], c[3])));
        chk("green", 32'(vif.green), 32'(lvl(c[1], c[3])));
        chk("blue",  32'(vif.blue),  32'(lvl(c[2], c[3])));
    endtask

    task automatic step();
        vd_hist[t] = vif.vdata;
        md_hist[t] = vif.mode;
        bd_hist[t] = vif.border;
        @(posedge clkVid);
        t++;
        #1;
        check_all();
        if (rand_vd) vif.vdata = 16'($urandom);
    endtask

    task automatic run_to(int target);
        while (t < target) step();
    endtask

    task automatic check_reset(string tag);
        chk({tag, "_hsync"}, 32'(vif.hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vif.vsync), 32'd1);
        chk({tag, "_blank"}, 32'(vif.blank), 32'd1);
        chk({tag, "_rdvid"}, 32'(vif.rdvid), 32'd0);
        chk({tag, "_fs"},    32'(vif.frame_start), 32'd0);
        chk({tag, "_rgb"},   32'({vif.red, vif.green, vif.blue}), 32'd0);
        chk({tag, "_vram"},  32'(vif.vram), 32'd0);
    endtask

    initial begin
        vif.mode   = 2'd1;
        vif.border = 4'h4;
        vif.vdata  = 16'h0000;
        #1 rst_n = 1'b0;
        #1 check_reset("rst");
        repeat (5) @(posedge clkVid);
        @(negedge clkVid);
        rst_n = 1'b1;
        t = 0;

        // Frame 0 runs on the reset shadow (mono, black border).
        run_to(F + 656);
        // Frame 1, row 5, column 2: colour8 byte 0x01A5.
        rand_vd = 1'b0;
        vif.vdata = 16'h01A5;
        run_to(F + 664);
        rand_vd = 1'b1;
        run_to(F + 665);
        pat = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            chk("c8_red",   32'(vif.red),   pat[7 - k] ? 32'h1F : 32'h0);
            chk("c8_green", 32'(vif.green), 32'h0);
            chk("c8_blue",  32'(vif.blue),  32'h0);
            step();
        end

        // Mid-frame change: frame 1 keeps colour8 and border 4.
        run_to(F + 16 * H);
        vif.mode   = 2'd2;
        vif.border = 4'h3;
        run_to(F + 26 * H + 11);
        chk("left_black", 32'({vif.red, vif.green, vif.blue}), 32'd0);
        run_to(F + 26 * H + 30);
        chk("border_blue",  32'(vif.blue), 32'h10);
        chk("border_rg",    32'({vif.red, vif.green}), 32'd0);
        chk("border_blank", 32'(vif.blank), 32'd1);

        // Frame 2, row 3, column 4: colour16 byte 0x3F0F.
        run_to(2 * F + 416);
        rand_vd = 1'b0;
        vif.vdata = 16'h3F0F;
        run_to(2 * F + 424);
        rand_vd = 1'b1;
        run_to(2 * F + 425);
        for (int k = 0; k < 8; k++) begin
            chk("c16_red",   32'(vif.red),   (k < 4) ? 32'h10 : 32'h1F);
            chk("c16_green", 32'(vif.green), (k < 4) ? 32'h10 : 32'h1F);
            chk("c16_blue",  32'(vif.blue),  (k < 4) ? 32'h00 : 32'h1F);
            step();
        end

        run_to(2 * F + 18 * H);
        vif.mode   = 2'd3;
        vif.border = 4'hB;
        run_to(3 * F + 18 * H);
        vif.mode   = 2'd0;
        vif.border = 4'h6;
        run_to(4 * F + 800);

        // Asynchronous reset mid-line, then restart from zero.
        #2 rst_n = 1'b0;
        #1 check_reset("rst2");
        repeat (3) @(posedge clkVid);
        @(negedge clkVid);
        rst_n = 1'b1;
        t = 0;
        run_to(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
